// File: rtl/move_sequencer_pkg.sv
// move_sequencer_pkg: shared face, turn and FSM state encodings for the move sequencer
package move_sequencer_pkg;
  typedef enum logic [2:0] {FACE_U, FACE_D, FACE_F, FACE_B, FACE_L, FACE_R} face_e;
  typedef enum logic [1:0] {TURN_ILLEGAL, TURN_CW, TURN_HALF, TURN_CCW} turns_e;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_CLR, WAIT_DONE, FAULT} state_e;
  localparam int MOVE_W = 5;
  function automatic logic legal_move(input logic [2:0] face, input logic [1:0] turns);
    return turns != TURN_ILLEGAL && face <= 3'(FACE_R);
  endfunction
endpackage

// File: rtl/move_fifo.sv
// move_fifo: synchronous FIFO with exact occupancy count
// ports: clock/reset, push/din write side, pop/dout read side, full/empty/count status
module move_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
    if (do_push) mem_q[wr_q] <= din;
  end
  assign dout  = mem_q[rd_q];
  assign full  = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: queues face moves and issues them one at a time to six stepper drivers
// ports: move_valid/face/turns/ready enqueue side; drv_start/steps/dir/done driver side;
//        busy, sticky fault and queue_count status
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int STEPS_PER_QUARTER = 50,
  parameter int QUEUE_DEPTH       = 16,
  parameter int DONE_TIMEOUT      = 2**20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       move_valid,
  input  logic [2:0] move_face,
  input  logic [1:0] move_turns,
  output logic       move_ready,
  output logic [5:0] drv_start,
  output logic [7:0] drv_steps,
  output logic [5:0] drv_dir,
  input  logic [5:0] drv_done,
  output logic       busy,
  output logic       fault,
  output logic [6:0] queue_count
);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  state_e state_q, state_d;
  logic [2:0] face_q, face_d;
  logic [7:0] steps_q, steps_d;
  logic [5:0] dir_q, dir_d;
  logic [TW-1:0] tmo_q, tmo_d, tmo_nx;
  logic [MOVE_W-1:0] head;
  logic [$clog2(QUEUE_DEPTH):0] count;
  logic full, empty, push, pop, illegal, done_sel;
  assign push     = move_valid && move_ready && legal_move(move_face, move_turns);
  assign illegal  = move_valid && move_ready && !legal_move(move_face, move_turns);
  assign pop      = state_q == IDLE && !empty && !illegal;
  assign done_sel = drv_done[face_q];
  move_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(MOVE_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({move_face, move_turns}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // tmo_q counts cycles since the launch cycle, so FAULT is entered exactly DONE_TIMEOUT cycles after it
  always_comb begin
    state_d = state_q;
    face_d  = face_q;
    steps_d = steps_q;
    dir_d   = dir_q;
    tmo_d   = tmo_q;
    tmo_nx  = tmo_q + TW'(1);
    case (state_q)
      IDLE: if (pop) begin
        state_d          = LAUNCH;
        face_d           = head[4:2];
        steps_d          = head[1:0] == TURN_HALF ? 8'(2 * STEPS_PER_QUARTER) : 8'(STEPS_PER_QUARTER);
        dir_d[head[4:2]] = head[1:0] != TURN_CCW;
        tmo_d            = '0;
      end
      LAUNCH: begin
        state_d = WAIT_CLR;
        tmo_d   = TW'(1);
      end
      WAIT_CLR, WAIT_DONE: begin
        tmo_d = tmo_nx;
        if (state_q == WAIT_CLR ? !done_sel : done_sel) state_d = state_q == WAIT_CLR ? WAIT_DONE : IDLE;
        else if (tmo_nx == TW'(DONE_TIMEOUT)) state_d = FAULT;
      end
      default: state_d = FAULT;
    endcase
    if (illegal) state_d = FAULT;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      face_q  <= '0;
      steps_q <= '0;
      dir_q   <= '1;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      face_q  <= face_d;
      steps_q <= steps_d;
      dir_q   <= dir_d;
      tmo_q   <= tmo_d;
    end
  end
  assign drv_start   = state_q == LAUNCH ? 6'b1 << face_q : '0;
  assign drv_steps   = steps_q;
  assign drv_dir     = dir_q;
  assign fault       = state_q == FAULT;
  assign move_ready  = !full && !fault;
  assign busy        = count != '0 || (state_q != IDLE && state_q != FAULT);
  assign queue_count = 7'(count);
endmodule
